// File: rtl/oneshot_pkg.sv
// -----------------------------------------------------------------------------
// oneshot_pkg
// Shared constants and types for the multi-channel one-shot block.
//   EDGE_RISE / EDGE_FALL / EDGE_BOTH : values for the EDGE_MODE parameter
//   rep_state_e                       : per-channel auto-repeat FSM states
//   max_int()                         : elaboration-time helper for widths
// Optional feature macro used by the block: ONESHOT_AUTOREPEAT_EN
// -----------------------------------------------------------------------------
package oneshot_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/oneshot_chan.sv
// -----------------------------------------------------------------------------
// oneshot_chan
// One button channel: 2-flop synchronizer, debounce counter, edge pulse and
// (with ONESHOT_AUTOREPEAT_EN defined) a hold/auto-repeat FSM.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   button    in   raw asynchronous button level (pressed = 1)
//   oneshot   out  registered one-cycle pulse
//   level     out  registered debounced level
//   pulse_nxt out  value oneshot takes at the next edge (feeds any_pulse)
// -----------------------------------------------------------------------------
module oneshot_chan
  import oneshot_pkg::*;
#(
  parameter int DB_CYCLES  = 4,
  parameter int EDGE_MODE  = EDGE_RISE,
  parameter int REP_DELAY  = 20,
  parameter int REP_PERIOD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic oneshot,
  output logic level,
  output logic pulse_nxt
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] db_cnt;

  // Level flips only after s2 has disagreed with it for DB_CYCLES edges.
  logic mismatch;
  logic qualify;
  logic level_nxt;
  logic rise;
  logic fall;
  logic edge_pulse;

  assign mismatch  = (s2 != level);
  assign qualify   = mismatch && (db_cnt == CW'(DB_CYCLES - 1));
  assign level_nxt = level ^ qualify;
  assign rise      = qualify && !level;
  assign fall      = qualify && level;

  assign edge_pulse = (EDGE_MODE == EDGE_BOTH) ? qualify :
                      (EDGE_MODE == EDGE_FALL) ? fall    : rise;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; blocking here would collapse s1/s2 into one stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      level  <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1    <= button;
      s2    <= s1;
      level <= level_nxt;
      // Any agreeing sample restarts qualification, so glitches never accumulate.
      if (!mismatch || qualify) db_cnt <= '0;
      else                      db_cnt <= db_cnt + CW'(1);
    end
  end

`ifdef ONESHOT_AUTOREPEAT_EN
  localparam int  RW     = $clog2(max_int(REP_DELAY, REP_PERIOD) + 1);
  // Falling-only mode never arms the repeat FSM.
  localparam bit  REP_ON = (EDGE_MODE != EDGE_FALL);

  rep_state_e    rep_state;
  logic [RW-1:0] rep_cnt;
  logic          rep_pulse;

  // Suppressed on the release edge so a coinciding release pulse stays single.
  assign rep_pulse = level_nxt &&
                     (((rep_state == HOLD)   && (rep_cnt == RW'(REP_DELAY - 1))) ||
                      ((rep_state == REPEAT) && (rep_cnt == RW'(REP_PERIOD - 1))));

  always_ff @(posedge clk) begin
    if (rst || !level_nxt) begin
      rep_state <= IDLE;
      rep_cnt   <= '0;
    end else begin
      case (rep_state)
        IDLE: begin
          rep_cnt <= '0;
          if (rise && REP_ON) rep_state <= HOLD;
        end
        HOLD: begin
          if (rep_cnt == RW'(REP_DELAY - 1)) begin
            rep_state <= REPEAT;
            rep_cnt   <= '0;
          end else begin
            rep_cnt <= rep_cnt + RW'(1);
          end
        end
        REPEAT: begin
          if (rep_cnt == RW'(REP_PERIOD - 1)) rep_cnt <= '0;
          else                                rep_cnt <= rep_cnt + RW'(1);
        end
        default: begin
          rep_state <= IDLE;
          rep_cnt   <= '0;
        end
      endcase
    end
  end

  assign pulse_nxt = edge_pulse | rep_pulse;
`else
  assign pulse_nxt = edge_pulse;
`endif

  always_ff @(posedge clk) begin
    if (rst) oneshot <= 1'b0;
    else     oneshot <= pulse_nxt;
  end

endmodule

// File: rtl/oneshot_multi.sv
// -----------------------------------------------------------------------------
// oneshot_multi
// N_CH independent debounced one-shot channels plus a combined pulse flag.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   button    in   [N_CH] raw button levels (pressed = 1)
//   oneShot   out  [N_CH] registered one-cycle pulses
//   level     out  [N_CH] registered debounced levels
//   any_pulse out  registered OR of all oneShot bits
// Optional feature macro: ONESHOT_AUTOREPEAT_EN (hold/auto-repeat pulses).
// -----------------------------------------------------------------------------
module oneshot_multi
  import oneshot_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DB_CYCLES  = 4,
  parameter int EDGE_MODE  = EDGE_RISE,
  parameter int REP_DELAY  = 20,
  parameter int REP_PERIOD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] oneShot,
  output logic [N_CH-1:0] level,
  output logic            any_pulse
);

  logic [N_CH-1:0] pulse_nxt;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    oneshot_chan #(
      .DB_CYCLES  (DB_CYCLES),
      .EDGE_MODE  (EDGE_MODE),
      .REP_DELAY  (REP_DELAY),
      .REP_PERIOD (REP_PERIOD)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .button    (button[i]),
      .oneshot   (oneShot[i]),
      .level     (level[i]),
      .pulse_nxt (pulse_nxt[i])
    );
  end

  // Registered from the same next-values as oneShot so both align exactly.
  always_ff @(posedge clk) begin
    if (rst) any_pulse <= 1'b0;
    else     any_pulse <= |pulse_nxt;
  end

endmodule

// File: doc/oneshot_multi.md
ONESHOT_MULTI -- requirements
Module: oneshot_multi

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels, legal range 1..32.
REQ-002 Parameter DB_CYCLES, default 4: debounce qualification length in clock cycles, minimum 1.
REQ-003 Parameter EDGE_MODE, default 0: pulse trigger; 0 rising, 1 falling, 2 both.
REQ-004 Parameters REP_DELAY (default 20) and REP_PERIOD (default 8): auto-repeat timing in cycles, minimum 1, used only under ONESHOT_AUTOREPEAT_EN.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 button  input  N_CH  raw asynchronous button levels, active-high (pressed = 1).
REQ-008 oneShot  output  N_CH  registered one-cycle pulse per channel.
REQ-009 level  output  N_CH  registered debounced level per channel.
REQ-010 any_pulse  output  1  registered OR of all oneShot bits.

Function
REQ-011 Each channel shall pass button through a 2-flop synchronizer (s1, s2) before any other logic.
REQ-012 Per-channel debounce counter, width $clog2(DB_CYCLES+1): increments on each edge where s2 != level; clears on any edge where s2 == level.
REQ-013 On the edge where s2 != level and counter == DB_CYCLES-1, level shall toggle and counter clear.
REQ-014 Latency: a stable change first sampled at edge 1 updates level at edge DB_CYCLES+2; any mismatch run shorter than DB_CYCLES cycles at s2 shall produce no level change.
REQ-015 oneShot[i] shall assert at the same edge level[i] changes, when the change matches EDGE_MODE, and deassert at the next edge.
REQ-016 oneShot pulses shall be exactly one cycle wide; holding a button shall never extend a pulse.
REQ-017 Channels shall be fully independent; simultaneous qualified edges on several channels pulse in the same cycle.
REQ-018 any_pulse shall equal the OR of the oneShot values being registered, so it is high in exactly the cycles where any oneShot bit is high.

Reset
REQ-019 While rst is high at an edge: s1, s2, level, counters, oneShot, any_pulse clear to 0, repeat FSM to IDLE.
REQ-020 Reset mid-operation (mid-debounce, mid-hold, mid-repeat) shall discard all progress; a button still held after reset release is treated as a fresh press, pulsing after REQ-014 latency (rising or both mode).

Configuration
REQ-021 Macro ONESHOT_AUTOREPEAT_EN: when defined, each channel adds a repeat FSM; when undefined, no FSM or repeat counters exist and behaviour is REQ-011..020 only.
REQ-022 FSM states IDLE, HOLD, REPEAT: IDLE->HOLD on rising level; HOLD counts REP_DELAY cycles then ->REPEAT with one extra pulse; REPEAT pulses every REP_PERIOD cycles; any state ->IDLE when level is 0.
REQ-023 Repeat pulses apply only when EDGE_MODE is 0 or 2; with EDGE_MODE 1 the FSM stays in IDLE.
REQ-024 A repeat pulse coinciding with a release-edge pulse (mode 2) shall yield a single one-cycle pulse.

Structure
REQ-025 Package oneshot_pkg holds EDGE_RISE/EDGE_FALL/EDGE_BOTH constants and the repeat-state enum.
REQ-026 Sub-module oneshot_chan implements one channel (sync, debounce, edge, repeat); oneshot_multi instantiates it N_CH times via generate and forms any_pulse.

Verification (N_CH=4, DB_CYCLES=4, 10 ns clock)
REQ-027 rst=1 for 2 edges with button=4'hF -> all outputs 0; after release, level=4'hF and oneShot=4'hF for one cycle at edge 6, any_pulse high same cycle.
REQ-028 button[0] high 3 cycles -> no pulse, level[0]=0; high 4 cycles -> exactly one pulse.
REQ-029 button[1] held 100 cycles, macro undefined -> exactly one pulse; macro defined (REP_DELAY=20, REP_PERIOD=8) -> pulse at press, +20 cycles, then every 8 until release.
REQ-030 EDGE_MODE=2, button[2] pressed 10 cycles then released -> two pulses, one per edge; EDGE_MODE=1 -> only release pulse.
REQ-031 rst pulsed one cycle while button[3] held in REPEAT -> outputs 0 next edge; new press pulse at edge 6 after rst release.
REQ-032 button[0] and button[3] rise in the same cycle -> oneShot=4'b1001 for one cycle, any_pulse high exactly one cycle.
